// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-output bundle for seq_pattern_tx.
// The requester drives start/pattern/repeat_cnt; the transmitter returns the serial stream.
interface seq_pattern_tx_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [3:0]       repeat_cnt;
  logic             out_bit;
  logic             out_valid;
  logic             ready;
  logic             done;

  modport master (
    output start, pattern, repeat_cnt,
    input  out_bit, out_valid, ready, done
  );

  modport slave (
    input  start, pattern, repeat_cnt,
    output out_bit, out_valid, ready, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured WIDTH-bit pattern MSB first,
// repeat_cnt+1 times, with GAP idle cycles between repetitions.
module seq_pattern_tx #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic          clk,
  input  logic          reset,
  seq_pattern_tx_if.slave tx
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_PEN  = IW'(WIDTH - 2);
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : {GW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] rot_r;
  logic [IW-1:0]    idx_r;
  logic [3:0]       rep_r;
  logic [GW-1:0]    gap_r;
  logic             out_bit_r;
  logic             out_valid_r;
  logic             done_r;

  // The pattern is kept as a rotating copy so the next bit to send is always
  // the MSB; after WIDTH rotations it is back to the captured value.
  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  // Transmit FSM with registered serial outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rot_r       <= {WIDTH{1'b0}};
      idx_r       <= {IW{1'b0}};
      rep_r       <= 4'd0;
      gap_r       <= {GW{1'b0}};
      out_bit_r   <= 1'b0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (tx.start) begin
            rot_r       <= rotl1(tx.pattern);
            rep_r       <= tx.repeat_cnt;
            idx_r       <= {IW{1'b0}};
            gap_r       <= {GW{1'b0}};
            out_bit_r   <= tx.pattern[WIDTH-1];
            out_valid_r <= 1'b1;
            done_r      <= 1'b0;
            state_r     <= ST_SHIFT;
          end else begin
            out_bit_r   <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (idx_r != IDX_LAST) begin
            idx_r       <= idx_r + 1'b1;
            out_bit_r   <= rot_r[WIDTH-1];
            rot_r       <= rotl1(rot_r);
            out_valid_r <= 1'b1;
            // Flag the bit about to be shown if it closes the final repetition.
            done_r      <= (idx_r == IDX_PEN) && (rep_r == 4'd0);
          end else if (rep_r == 4'd0) begin
            state_r     <= ST_IDLE;
            out_bit_r   <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
          end else if (GAP == 0) begin
            rep_r       <= rep_r - 4'd1;
            idx_r       <= {IW{1'b0}};
            out_bit_r   <= rot_r[WIDTH-1];
            rot_r       <= rotl1(rot_r);
            out_valid_r <= 1'b1;
            done_r      <= 1'b0;
          end else begin
            rep_r       <= rep_r - 4'd1;
            gap_r       <= {GW{1'b0}};
            state_r     <= ST_GAP;
            out_bit_r   <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
          end
        end

        ST_GAP: begin
          if (gap_r == GAP_LAST) begin
            state_r     <= ST_SHIFT;
            idx_r       <= {IW{1'b0}};
            out_bit_r   <= rot_r[WIDTH-1];
            rot_r       <= rotl1(rot_r);
            out_valid_r <= 1'b1;
            done_r      <= 1'b0;
          end else begin
            gap_r       <= gap_r + 1'b1;
            out_bit_r   <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          out_bit_r   <= 1'b0;
          out_valid_r <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign tx.ready     = (state_r == ST_IDLE);
  assign tx.out_bit   = out_bit_r;
  assign tx.out_valid = out_valid_r;
  assign tx.done      = done_r;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed and random transfers on a GAP=1 and a GAP=0
// instance, checked cycle by cycle against a timeline computed from the pattern rules.
module tb_seq_pattern_tx;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] pattern;
  logic [3:0]   repeat_cnt;
  logic         sel;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  seq_pattern_tx_if #(.WIDTH(W)) bus1 ();
  seq_pattern_tx_if #(.WIDTH(W)) bus0 ();

  assign bus1.start      = start & ~sel;
  assign bus1.pattern    = pattern;
  assign bus1.repeat_cnt = repeat_cnt;
  assign bus0.start      = start & sel;
  assign bus0.pattern    = pattern;
  assign bus0.repeat_cnt = repeat_cnt;

  seq_pattern_tx #(.WIDTH(W), .GAP(1)) dut  (.clk(clk), .reset(reset), .tx(bus1.slave));
  seq_pattern_tx #(.WIDTH(W), .GAP(0)) dut0 (.clk(clk), .reset(reset), .tx(bus0.slave));

  // {ready, done, out_valid, out_bit} of the selected instance
  wire [3:0] obs = sel ? {bus0.ready, bus0.done, bus0.out_valid, bus0.out_bit}
                       : {bus1.ready, bus1.done, bus1.out_valid, bus1.out_bit};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // mode 0: quiet inputs while busy; 1: busy start pulses (zero pattern in cycle 3);
  // 2: start held high throughout
  task automatic run_tx(input logic [W-1:0] p, input logic [3:0] rc, input int mode);
    int gap, reps, len, period, pos;
    logic ev, eb, ed;
    gap    = sel ? 0 : 1;
    reps   = int'(rc) + 1;
    len    = reps * W + (reps - 1) * gap;
    period = W + gap;
    check("ready_before_start", {28'd0, obs[3]}, 32'd1);
    start = 1'b1; pattern = p; repeat_cnt = rc;
    @(posedge clk); #1;
    start = 1'b0; pattern = W'($urandom); repeat_cnt = 4'($urandom);
    for (int c = 0; c < len; c++) begin
      pos = c % period;
      ev  = (pos < W);
      eb  = ev ? p[W-1-pos] : 1'b0;
      ed  = (c == len - 1);
      check($sformatf("tx_cycle%0d", c + 1), {28'd0, obs}, {28'd0, 1'b0, ed, ev, eb});
      if (mode == 1) begin
        start   = (c == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        pattern = (c == 1) ? 4'b0000 : W'($urandom);
      end else if (mode == 2) begin
        start   = 1'b1;
        pattern = W'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("idle_after_done", {28'd0, obs}, 32'h8);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sel = 1'b0; pattern = 4'b0000; repeat_cnt = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state_gap1", {28'd0, bus1.ready, bus1.done, bus1.out_valid, bus1.out_bit}, 32'h8);
    check("reset_state_gap0", {28'd0, bus0.ready, bus0.done, bus0.out_valid, bus0.out_bit}, 32'h8);
    reset = 1'b0;
    @(posedge clk); #1;

    run_tx(4'b1011, 4'd0, 0);           // basic send
    run_tx(4'b1011, 4'd1, 0);           // repeat with gap
    run_tx(4'b1011, 4'd1, 1);           // busy starts ignored
    check("no_restart_after_busy", {28'd0, obs}, 32'h8);

    // Reset during bit 2 aborts without done
    start = 1'b1; pattern = 4'b1011; repeat_cnt = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_bit0", {28'd0, obs}, 32'h3);
    @(posedge clk); #1;
    check("abort_bit1", {28'd0, obs}, 32'h2);
    @(posedge clk); #1;
    check("abort_bit2", {28'd0, obs}, 32'h3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("after_abort", {28'd0, obs}, 32'h8);
    @(posedge clk); #1;
    check("after_abort_no_done", {28'd0, obs}, 32'h8);
    run_tx(4'b1011, 4'd0, 0);

    // Reset wins over a simultaneous start
    reset = 1'b1; start = 1'b1; pattern = 4'b1111;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check("reset_over_start", {28'd0, obs}, 32'h8);
    @(posedge clk); #1;
    check("reset_over_start_hold", {28'd0, obs}, 32'h8);

    // Back-to-back starts
    run_tx(4'b1100, 4'd0, 2);
    run_tx(4'b1100, 4'd0, 2);
    run_tx(4'b1100, 4'd0, 2);

    // Boundary: 16 repetitions, no gap
    sel = 1'b1;
    run_tx(4'b1001, 4'd15, 0);
    @(posedge clk); #1;
    check("no_17th_rep", {28'd0, obs}, 32'h8);
    sel = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 12; k++) begin
      sel = 1'($urandom_range(0, 1));
      run_tx(W'($urandom), 4'($urandom_range(0, 5)), $urandom_range(0, 2));
    end
    sel = 1'b1;
    run_tx(W'($urandom), 4'd15, 1);
    sel = 1'b0;
    run_tx(W'($urandom), 4'd15, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
